// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the fetch stage: next-PC select encodings,
// fault cause codes, FSM states and default address-map constants.
package riscv_fetch_pkg;

  // Next-PC select encodings (2'b11 is reserved and behaves as PLUS4)
  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_TARGET = 2'b01;
  localparam logic [1:0] PC_SRC_JALR   = 2'b10;

  // Fetch fault cause codes
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  // Fetch control FSM states
  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } fetch_state_t;

  // Default address map
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_1000;
  localparam logic [31:0] DEFAULT_IMEM_BASE    = 32'h0000_1000;
  localparam int unsigned DEFAULT_IMEM_WORDS   = 65535;

  // True when addr lies in [base, base + 4*words). Evaluated in 34 bits so
  // the upper bound never wraps, even for a region ending at 2^32.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] words);
    logic [33:0] a_ext;
    logic [33:0] lo_ext;
    logic [33:0] hi_ext;
    a_ext  = {2'b00, addr};
    lo_ext = {2'b00, base};
    hi_ext = lo_ext + {words, 2'b00};
    return (a_ext >= lo_ext) && (a_ext < hi_ext);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection and target legality check.
// Produces pc+4, pc+imm, the selected next PC and a fault cause for it
// (misalignment takes priority over out-of-range).
module pc_next_sel
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE  = DEFAULT_IMEM_BASE,
  parameter int unsigned IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic [31:0] pc_next,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_target,
  output logic        bad,
  output logic [1:0]  cause
);

  // Both adders wrap modulo 2^32 by construction
  assign pc_plus4  = pc + 32'd4;
  assign pc_target = pc + imm_ext;

  // Select the candidate PC; jalr clears bit 0 of the computed address
  always_comb begin
    pc_next = pc_plus4;
    case (pc_src)
      PC_SRC_TARGET: pc_next = pc_target;
      PC_SRC_JALR:   pc_next = alu_result & ~32'h1;
      default:       pc_next = pc_plus4;
    endcase
  end

  // Classify the candidate; misalignment wins over range
  always_comb begin
    cause = FAULT_NONE;
    if (pc_next[1:0] != 2'b00) begin
      cause = FAULT_MISALIGN;
    end else if (!addr_in_range(pc_next, IMEM_BASE, IMEM_WORDS)) begin
      cause = FAULT_RANGE;
    end
  end

  assign bad = (cause != FAULT_NONE);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter / fetch-control stage feeding instruction memory.
// Holds the PC, runs the BOOT/RUN/HALT control FSM, latches sticky fetch
// faults and optionally counts PC advances.
// Build option: define PC_FETCH_COUNT_EN to implement the fetch_count
// register; otherwise fetch_count is tied to zero.
module pc_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] IMEM_BASE    = DEFAULT_IMEM_BASE,
  parameter int unsigned IMEM_WORDS   = DEFAULT_IMEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_target,
  output logic        instr_valid,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fetch_count
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         fault_reg, fault_next;
  logic [1:0]   cause_reg, cause_next;

  logic [31:0]  pc_candidate;
  logic         candidate_bad;
  logic [1:0]   candidate_cause;

  pc_next_sel #(
    .IMEM_BASE  (IMEM_BASE),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_sel (
    .pc         (pc_reg),
    .pc_src     (pc_src),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .pc_next    (pc_candidate),
    .pc_plus4   (pc_plus4),
    .pc_target  (pc_target),
    .bad        (candidate_bad),
    .cause      (candidate_cause)
  );

  // State, PC and fault registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_VECTOR;
      fault_reg <= 1'b0;
      cause_reg <= FAULT_NONE;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
      cause_reg <= cause_next;
    end
  end

  // Next-state logic: advance or halt only in RUN with en; HALT is terminal
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    fault_next = fault_reg;
    cause_next = cause_reg;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        if (en) begin
          if (candidate_bad) begin
            fault_next = 1'b1;
            cause_next = candidate_cause;
            state_next = HALT;
          end else begin
            pc_next = pc_candidate;
          end
        end
      end
      HALT: state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

`ifdef PC_FETCH_COUNT_EN
  logic [31:0] count_reg;
  logic        advance;

  // A commit is exactly the case where the PC is allowed to move
  assign advance = (state_reg == RUN) && en && !candidate_bad;

  // Fetch counter, wraps modulo 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 32'h0;
    end else if (advance) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign fetch_count = count_reg;
`else
  assign fetch_count = 32'h0;
`endif

  assign pc          = pc_reg;
  assign instr_valid = (state_reg == RUN);
  assign fault       = fault_reg;
  assign fault_cause = cause_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a cycle model predicts the
// registered outputs, pushes them to a scoreboard queue when stimulus is
// driven, and pops/compares them after the clock edge.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] imm_ext = 32'h0;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] pc, pc_plus4, pc_target, fetch_count;
  logic        instr_valid, fault;
  logic [1:0]  fault_cause;

  pc_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .pc_src      (pc_src),
    .imm_ext     (imm_ext),
    .alu_result  (alu_result),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pc_target   (pc_target),
    .instr_valid (instr_valid),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_txn = 0;

  // Reference model state: 0 = boot, 1 = run, 2 = halt
  int          m_st;
  logic [31:0] m_pc;
  logic        m_fault;
  logic [1:0]  m_cause;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pc    = m_pc;
    e.valid = (m_st == 1);
    e.fault = m_fault;
    e.cause = m_cause;
`ifdef PC_FETCH_COUNT_EN
    e.cnt   = m_cnt;
`else
    e.cnt   = 32'h0;
`endif
    return e;
  endfunction

  task automatic pop_and_compare(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, ".pc"},    pc, e.pc);
    chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, e.valid});
    chk({tag, ".fault"}, {31'h0, fault}, {31'h0, e.fault});
    chk({tag, ".cause"}, {30'h0, fault_cause}, {30'h0, e.cause});
    chk({tag, ".count"}, fetch_count, e.cnt);
    $display("txn %0d %s: pc=%h valid=%0b fault=%0b cause=%0d count=%0d",
             n_txn, tag, pc, instr_valid, fault, fault_cause, fetch_count);
    n_txn++;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    en    = 1'b1;
    m_st = 0; m_pc = 32'h1000; m_fault = 1'b0; m_cause = 2'b00; m_cnt = 32'h0;
    sb.push_back(model_snapshot());
    @(posedge clk); #1;
    reset = 1'b0;
    pop_and_compare(tag);
  endtask

  // One clock of stimulus with combinational and registered checks
  task automatic step(input string tag, input logic e_in, input logic [1:0] src,
                      input logic [31:0] imm, input logic [31:0] alu);
    logic [31:0] p4, tg, nx;
    en = e_in; pc_src = src; imm_ext = imm; alu_result = alu;
    p4 = m_pc + 32'd4;
    tg = m_pc + imm;
    #1;
    chk({tag, ".plus4"},  pc_plus4,  p4);
    chk({tag, ".target"}, pc_target, tg);
    if (m_st == 0) begin
      m_st = 1;
    end else if (m_st == 1 && e_in) begin
      if (src == 2'b01)      nx = tg;
      else if (src == 2'b10) nx = {alu[31:1], 1'b0};
      else                   nx = p4;
      if (nx[1:0] != 2'b00) begin
        m_fault = 1'b1; m_cause = 2'b01; m_st = 2;
      end else if (nx < 32'h0000_1000 || nx >= 32'h0004_0FFC) begin
        m_fault = 1'b1; m_cause = 2'b10; m_st = 2;
      end else begin
        m_pc = nx; m_cnt = m_cnt + 32'd1;
      end
    end
    sb.push_back(model_snapshot());
    @(posedge clk); #1;
    pop_and_compare(tag);
  endtask

  initial begin
    int signed off;
    logic [31:0] imm_r, alu_r;
    @(posedge clk); #1;

    // Sequential fetch from reset
    do_reset("reset0");
    step("boot",  1'b1, 2'b00, 32'h0, 32'h0);
    step("seq1",  1'b1, 2'b00, 32'h0, 32'h0);
    step("seq2",  1'b1, 2'b00, 32'h0, 32'h0);
    chk("seq_pc", pc, 32'h0000_1008);
    step("seq3",  1'b1, 2'b11, 32'h0, 32'h0);   // reserved select acts as +4
    chk("rsv_pc", pc, 32'h0000_100C);

    // Backward branch (beq x4,x4,-12)
    step("branch", 1'b1, 2'b01, 32'hFFFF_FFF4, 32'h0);
    chk("branch_pc", pc, 32'h0000_1000);
    step("seq4", 1'b1, 2'b00, 32'h0, 32'h0);
    step("seq5", 1'b1, 2'b00, 32'h0, 32'h0);

    // Stall with a misaligned jalr target presented: no fault
    for (int i = 0; i < 4; i++) step("stall", 1'b0, 2'b10, 32'h0, 32'h0000_1003);
    chk("stall_fault", {31'h0, fault}, 32'h0);

    // jalr clears bit 0, then a misaligned target halts
    step("jalr_ok",  1'b1, 2'b10, 32'h0, 32'h0000_1011);
    chk("jalr_pc", pc, 32'h0000_1010);
    step("jalr_bad", 1'b1, 2'b10, 32'h0, 32'h0000_1012);
    chk("misalign_cause", {30'h0, fault_cause}, 32'h1);
    for (int i = 0; i < 3; i++) step("halt", 1'b1, 2'b00, 32'h0, 32'h0);

    // Reset out of HALT, then an out-of-range branch
    do_reset("reset1");
    step("boot", 1'b1, 2'b00, 32'h0, 32'h0);
    step("range", 1'b1, 2'b01, 32'hFFFF_F000, 32'h0);
    chk("range_cause", {30'h0, fault_cause}, 32'h2);
    for (int i = 0; i < 3; i++) step("halt", 1'b1, 2'b01, 32'h4, 32'h0);

    // Upper edge of the legal window: last word legal, next one not
    do_reset("reset2");
    step("boot", 1'b1, 2'b00, 32'h0, 32'h0);
    step("jalr_last", 1'b1, 2'b10, 32'h0, 32'h0004_0FF8);
    chk("last_pc", pc, 32'h0004_0FF8);
    step("plus4_over", 1'b1, 2'b00, 32'h0, 32'h0);

    // Reset in the middle of RUN
    do_reset("reset3");
    step("boot", 1'b1, 2'b00, 32'h0, 32'h0);
    step("seq", 1'b1, 2'b00, 32'h0, 32'h0);
    do_reset("reset_run");

    // Random mix of selects, stalls and occasional bad targets
    for (int i = 0; i < 60; i++) begin
      if (m_st == 2) do_reset("reset_rnd");
      off   = $urandom_range(0, 31);
      off   = off - 12;
      imm_r = 32'(off * 4);
      if ($urandom_range(0, 15) == 0) imm_r = imm_r + 32'd2;
      alu_r = m_pc + 32'(off * 4) + 32'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) alu_r = alu_r + 32'd2;
      step("rnd", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), imm_r, alu_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
